// File: rtl/spi_slave_frame_rx_pkg.sv
// Shared types and constants for the SPI slave frame receiver: FSM states,
// the idle levels of the SPI lines, and frame-size arithmetic.
package spi_slave_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic SS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  function automatic int unsigned frame_bits(input int unsigned bytes);
    return 8 * bytes;
  endfunction

endpackage

// File: rtl/spi_slave_frame_rx_if.sv
// SPI pins plus the frame-side handshake of the display SPI slave.
interface spi_slave_frame_rx_if #(
  parameter int unsigned FRAME_BITS = 16
);
  logic                  spi_sclk_i;
  logic                  spi_ss_i;
  logic                  spi_mosi_i;
  logic                  spi_miso_o;
  logic [FRAME_BITS-1:0] tx_data_i;
  logic [FRAME_BITS-1:0] frame_data_o;
  logic                  frame_valid_o;
  logic                  frame_err_o;
  logic                  busy_o;

  modport slave (
    input  spi_sclk_i, spi_ss_i, spi_mosi_i, tx_data_i,
    output spi_miso_o, frame_data_o, frame_valid_o, frame_err_o, busy_o
  );

  modport master (
    output spi_sclk_i, spi_ss_i, spi_mosi_i, tx_data_i,
    input  spi_miso_o, frame_data_o, frame_valid_o, frame_err_o, busy_o
  );
endinterface

// File: rtl/spi_slave_frame_rx_in_sync.sv
// 1-bit synchroniser with a history flop; rise/fall compare the synchronised
// level against its one-cycle-old copy.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_VAL    = 1'b0
) (
  input  logic block_clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge block_clk_i) begin
    if (rst_i) begin
      chain <= {SYNC_STAGES{IDLE_VAL}};
      hist  <= IDLE_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign q      = chain[SYNC_STAGES-1];
  assign rise_c = q & ~hist;
  assign fall_c = ~q & hist;
endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI mode-0 slave that assembles MSB-first frames in the block clock domain.
// Optional MISO status return is built when SPI_SLAVE_MISO_EN is defined.
module spi_slave_frame_rx
  import spi_slave_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 block_clk_i,
  input  logic                 rst_i,
  spi_slave_frame_rx_if.slave  bus
);
  localparam int unsigned FRAME_BITS = frame_bits(FRAME_BYTES);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [0:0]  ST_IDLE    = IDLE;
  localparam logic [0:0]  ST_SHIFT   = SHIFT;

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(SCLK_IDLE)) u_sclk_sync (
    .block_clk_i(block_clk_i), .rst_i(rst_i), .d(bus.spi_sclk_i),
    .q(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(SS_IDLE)) u_ss_sync (
    .block_clk_i(block_clk_i), .rst_i(rst_i), .d(bus.spi_ss_i),
    .q(ss_s), .rise_c(ss_rise), .fall_c(ss_fall)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(MOSI_IDLE)) u_mosi_sync (
    .block_clk_i(block_clk_i), .rst_i(rst_i), .d(bus.spi_mosi_i),
    .q(mosi_s), .rise_c(mosi_rise), .fall_c(mosi_fall)
  );

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
`ifdef SPI_SLAVE_MISO_EN
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                  unused_sigs;
  assign unused_sigs = ^{sclk_s, mosi_rise, mosi_fall};
`else
  logic                  unused_sigs;
  assign unused_sigs = ^{sclk_s, sclk_fall, mosi_rise, mosi_fall, bus.tx_data_i};
`endif

  always_ff @(posedge block_clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      frame_data_q <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      tx_shift_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      frame_data_q <= frame_data_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
`ifdef SPI_SLAVE_MISO_EN
      tx_shift_q   <= tx_shift_d;
`endif
    end
  end

  // Completion outranks SS release; SS release outranks a coincident SCLK edge.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    frame_data_d = frame_data_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
`ifdef SPI_SLAVE_MISO_EN
    tx_shift_d   = tx_shift_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
`ifdef SPI_SLAVE_MISO_EN
          tx_shift_d = bus.tx_data_i;
`endif
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
          frame_data_d = rx_shift_q;
          valid_d      = 1'b1;
          bit_cnt_d    = '0;
`ifdef SPI_SLAVE_MISO_EN
          tx_shift_d   = bus.tx_data_i;
`endif
          if (ss_rise) state_d = ST_IDLE;
        end else if (ss_rise) begin
          err_d     = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
`ifdef SPI_SLAVE_MISO_EN
          // The fall trailing a frame's last rise must not eat the reloaded MSB.
          if (sclk_fall && (bit_cnt_q != '0)) tx_shift_d = tx_shift_q << 1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.frame_data_o  = frame_data_q;
  assign bus.frame_valid_o = valid_q;
  assign bus.frame_err_o   = err_q;
  assign bus.busy_o        = ~ss_s;
`ifdef SPI_SLAVE_MISO_EN
  assign bus.spi_miso_o    = (state_q == ST_SHIFT) & tx_shift_q[FRAME_BITS-1];
`else
  assign bus.spi_miso_o    = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Directed bench for spi_slave_frame_rx; honours SPI_SLAVE_MISO_EN when defined.
module tb_spi_slave_frame_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  spi_slave_frame_rx_if #(.FRAME_BITS(16)) bus();

  spi_slave_frame_rx #(.FRAME_BYTES(2), .SYNC_STAGES(2)) dut (
    .block_clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          busy_drops = 0;
  int          miso_hi = 0;
  bit          busy_watch = 1'b0;
  logic [15:0] vq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_valid_o) begin
        valid_cnt++;
        vq.push_back(bus.frame_data_o);
      end
      if (bus.frame_err_o) err_cnt++;
      if (busy_watch && !bus.busy_o) busy_drops++;
      if (bus.spi_miso_o !== 1'b0) miso_hi++;
    end
  end

  task automatic spi_bit(input logic b, input int half, output logic miso_s);
    bus.spi_mosi_i = b;
    repeat (half) @(negedge clk);
    bus.spi_sclk_i = 1'b1;
    miso_s = bus.spi_miso_o;
    repeat (half) @(negedge clk);
    bus.spi_sclk_i = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, input int half,
                           output logic [15:0] miso_w);
    logic m;
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(word[15-i], half, m);
      miso_w = {miso_w[14:0], m};
    end
  endtask

  task automatic ss_begin(input int half);
    bus.spi_ss_i = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (4) @(negedge clk);
    bus.spi_ss_i = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.spi_sclk_i = 1'b0;
    bus.spi_ss_i   = 1'b1;
    bus.spi_mosi_i = 1'b0;
    bus.tx_data_i  = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (bus.frame_data_o !== 16'h0000) $display("FAIL reset_data: got %h want 0000", bus.frame_data_o); else n_pass++;
    n_total++; if (bus.frame_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.frame_valid_o); else n_pass++;
    n_total++; if (bus.frame_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.frame_err_o); else n_pass++;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else n_pass++;
    n_total++; if (bus.spi_miso_o !== 1'b0) $display("FAIL reset_miso: got %b want 0", bus.spi_miso_o); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int v0 = valid_cnt, e0 = err_cnt;
    logic [15:0] m;
    ss_begin(2);
    spi_frame(16'h1308, 16, 2, m);
    ss_end();
    n_total++; if (valid_cnt - v0 !== 1) $display("FAIL single_valid_cnt: got %0d want 1", valid_cnt - v0); else n_pass++;
    n_total++; if (bus.frame_data_o !== 16'h1308) $display("FAIL single_data: got %h want 1308", bus.frame_data_o); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL single_err_cnt: got %0d want 0", err_cnt - e0); else n_pass++;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL single_busy_after: got %b want 0", bus.busy_o); else n_pass++;
  endtask

  task automatic test_error();
    int v0 = valid_cnt, e0 = err_cnt;
    logic [15:0] m;
    ss_begin(2);
    spi_frame(16'hFFFF, 11, 2, m);
    ss_end();
    n_total++; if (err_cnt - e0 !== 1) $display("FAIL err_cnt: got %0d want 1", err_cnt - e0); else n_pass++;
    n_total++; if (valid_cnt - v0 !== 0) $display("FAIL err_valid_cnt: got %0d want 0", valid_cnt - v0); else n_pass++;
    n_total++; if (bus.frame_data_o !== 16'h1308) $display("FAIL err_data_kept: got %h want 1308", bus.frame_data_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt, e0 = err_cnt, b0 = busy_drops;
    int q0 = vq.size();
    logic [15:0] m;
    ss_begin(2);
    repeat (2) @(negedge clk);
    busy_watch = 1'b1;
    spi_frame(16'h1102, 16, 2, m);
    spi_frame(16'h0A0F, 16, 2, m);
    repeat (3) @(negedge clk);
    busy_watch = 1'b0;
    ss_end();
    n_total++; if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_cnt: got %0d want 2", valid_cnt - v0); else n_pass++;
    n_total++;
    if (vq.size() < q0 + 2) $display("FAIL b2b_first: only %0d frames captured, want 2", vq.size() - q0);
    else if (vq[q0] !== 16'h1102) $display("FAIL b2b_first: got %h want 1102", vq[q0]);
    else n_pass++;
    n_total++;
    if (vq.size() < q0 + 2) $display("FAIL b2b_second: only %0d frames captured, want 2", vq.size() - q0);
    else if (vq[q0+1] !== 16'h0A0F) $display("FAIL b2b_second: got %h want 0a0f", vq[q0+1]);
    else n_pass++;
    n_total++; if (busy_drops - b0 !== 0) $display("FAIL b2b_busy: busy low for %0d cycles, want 0", busy_drops - b0); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL b2b_err_cnt: got %0d want 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_miso();
    int v0 = valid_cnt, h0 = miso_hi;
    logic [15:0] m;
    bus.tx_data_i = 16'hA55A;
    ss_begin(8);
    spi_frame(16'h0000, 16, 8, m);
    ss_end();
`ifdef SPI_SLAVE_MISO_EN
    n_total++; if (m !== 16'hA55A) $display("FAIL miso_word: got %h want a55a", m); else n_pass++;
`else
    n_total++; if (miso_hi - h0 !== 0) $display("FAIL miso_tied: high for %0d cycles, want 0", miso_hi - h0); else n_pass++;
    n_total++; if (m !== 16'h0000) $display("FAIL miso_word: got %h want 0000", m); else n_pass++;
`endif
    n_total++; if (valid_cnt - v0 !== 1) $display("FAIL miso_valid_cnt: got %0d want 1", valid_cnt - v0); else n_pass++;
    n_total++; if (bus.frame_data_o !== 16'h0000) $display("FAIL miso_data: got %h want 0000", bus.frame_data_o); else n_pass++;
    bus.tx_data_i = 16'h0000;
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0, q0;
    logic [15:0] m;
    ss_begin(2);
    spi_frame(16'hFFFF, 7, 2, m);
    rst = 1'b1;
    bus.spi_ss_i = 1'b1;
    bus.spi_sclk_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_total++; if (bus.frame_data_o !== 16'h0000) $display("FAIL rstmid_cleared: got %h want 0000", bus.frame_data_o); else n_pass++;
    v0 = valid_cnt; e0 = err_cnt; q0 = vq.size();
    ss_begin(2);
    spi_frame(16'h0102, 16, 2, m);
    ss_end();
    n_total++; if (valid_cnt - v0 !== 1) $display("FAIL rstmid_valid_cnt: got %0d want 1", valid_cnt - v0); else n_pass++;
    n_total++;
    if (vq.size() < q0 + 1) $display("FAIL rstmid_data: no frame captured, want 0102");
    else if (vq[q0] !== 16'h0102) $display("FAIL rstmid_data: got %h want 0102", vq[q0]);
    else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL rstmid_err_cnt: got %0d want 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_stray_sclk();
    int v0 = valid_cnt, e0 = err_cnt;
    logic [15:0] m;
    for (int i = 0; i < 6; i++) begin
      bus.spi_mosi_i = 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
      bus.spi_sclk_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.spi_sclk_i = 1'b0;
    end
    repeat (6) @(negedge clk);
    n_total++; if (valid_cnt - v0 !== 0) $display("FAIL stray_no_valid: got %0d want 0", valid_cnt - v0); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL stray_no_err: got %0d want 0", err_cnt - e0); else n_pass++;
    ss_begin(2);
    spi_frame(16'h00FF, 16, 2, m);
    ss_end();
    n_total++; if (valid_cnt - v0 !== 1) $display("FAIL stray_valid_cnt: got %0d want 1", valid_cnt - v0); else n_pass++;
    n_total++; if (bus.frame_data_o !== 16'h00FF) $display("FAIL stray_data: got %h want 00ff", bus.frame_data_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_error();
    test_back_to_back();
    test_miso();
    test_reset_mid_frame();
    test_stray_sclk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
